// File: rtl/overture_fetch_8bit_if.sv
// Overture 8-bit fetch bus: program-memory req/ack channel, decoder
// valid/ready channel, and the redirect port from the execute stage.
interface overture_fetch_8bit_if #(
  parameter int PC_W = 8
);
  logic            mem_req;
  logic [PC_W-1:0] mem_addr;
  logic            mem_ack;
  logic [7:0]      mem_rdata;
  logic [7:0]      instr;
  logic [PC_W-1:0] instr_pc;
  logic            instr_valid;
  logic            instr_ready;
  logic            redirect;
  logic [PC_W-1:0] redirect_pc;

  // Fetch stage side
  modport master (
    output mem_req, mem_addr, instr, instr_pc, instr_valid,
    input  mem_ack, mem_rdata, instr_ready, redirect, redirect_pc
  );

  // Memory / decoder / execute side
  modport slave (
    input  mem_req, mem_addr, instr, instr_pc, instr_valid,
    output mem_ack, mem_rdata, instr_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/overture_fetch_8bit.sv
// Overture 8-bit instruction fetch stage: PC, single-outstanding memory
// request, one-entry instruction register, and redirect/squash handling.
module overture_fetch_8bit #(
  parameter int          PC_W     = 8,
  parameter int unsigned RESET_PC = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  overture_fetch_8bit_if.master  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DROP  = 2'd2,
    FULL  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] tgt_q, tgt_d;
  logic [7:0]      instr_q, instr_d;
  logic [PC_W-1:0] ipc_q, ipc_d;

  // Sequential PC advance; wraps naturally at 2^PC_W
  function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] p);
    return p + PC_W'(1);
  endfunction

  // State and datapath registers; reset abandons any in-flight request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= PC_W'(RESET_PC);
      tgt_q   <= '0;
      instr_q <= 8'h00;
      ipc_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
    end
  end

  // Next-state logic; redirect outranks every other event in every state
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    tgt_d   = tgt_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    unique case (state_q)
      IDLE: begin
        if (bus.redirect) pc_d = bus.redirect_pc;
        state_d = FETCH;
      end
      FETCH: begin
        if (bus.mem_ack && !bus.redirect) begin
          instr_d = bus.mem_rdata;
          ipc_d   = pc_q;
          pc_d    = pc_inc(pc_q);
          state_d = FULL;
        end else if (bus.mem_ack) begin
          // Returned byte is wrong-path; restart at the target right away
          pc_d = bus.redirect_pc;
        end else if (bus.redirect) begin
          // Request is in flight and the address must stay put; park target
          tgt_d   = bus.redirect_pc;
          state_d = DROP;
        end
      end
      DROP: begin
        if (bus.mem_ack) begin
          pc_d    = bus.redirect ? bus.redirect_pc : tgt_q;
          state_d = FETCH;
        end else if (bus.redirect) begin
          tgt_d = bus.redirect_pc;
        end
      end
      FULL: begin
        if (bus.redirect) begin
          pc_d    = bus.redirect_pc;
          state_d = FETCH;
        end else if (bus.instr_ready) begin
          state_d = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs are pure decodes of the state
  always_comb begin
    bus.mem_req     = (state_q == FETCH) || (state_q == DROP);
    bus.mem_addr    = pc_q;
    bus.instr_valid = (state_q == FULL);
    bus.instr       = instr_q;
    bus.instr_pc    = ipc_q;
  end

endmodule

// File: doc/overture_fetch_8bit.md
# overture_fetch_8bit

Instruction fetch stage for the Overture 8-bit CPU. Keeps the program counter, runs a req/ack handshake to program memory with any number of wait states, and holds each fetched byte in a one-entry instruction register. That register feeds `overture_decoder_8bit` through a valid/ready handshake. The execute/condition stage drives a redirect port for taken jumps; a redirect squashes the buffered or in-flight wrong-path instruction.

## Interface
Parameters:
- `PC_W`, default 8: program counter and memory address width.
- `RESET_PC`, default 0: first fetch address after reset.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `mem_req`  out  1  fetch request to program memory.
- `mem_addr`  out  PC_W  fetch address; stable while `mem_req` is high and not yet acked.
- `mem_ack`  in  1  memory completes the request this cycle.
- `mem_rdata`  in  8  instruction byte; valid only when `mem_ack` is high.
- `instr`  out  8  buffered instruction, to the decoder.
- `instr_pc`  out  PC_W  address `instr` was fetched from.
- `instr_valid`  out  1  `instr` is valid.
- `instr_ready`  in  1  consumer accepts `instr` this cycle.
- `redirect`  in  1  taken jump; restart fetch at `redirect_pc`.
- `redirect_pc`  in  PC_W  jump target.

## Operation
Internal state: `pc` (next fetch address), `tgt` (pending redirect target), `instr`, `instr_pc`, and the FSM. `mem_req` and `instr_valid` are decoded from the FSM state.

FSM states:
- IDLE: `mem_req`=0, `instr_valid`=0. Unconditionally moves to FETCH next cycle. If `redirect` is high, `pc` <= `redirect_pc`.
- FETCH: `mem_req`=1, `mem_addr`=`pc`.
  - `mem_ack` and no `redirect`: `instr` <= `mem_rdata`, `instr_pc` <= `pc`, `pc` <= `pc`+1 (mod 2^PC_W, 0xFF wraps to 0x00); go to FULL.
  - `mem_ack` and `redirect`: drop the data, `pc` <= `redirect_pc`, stay in FETCH.
  - `redirect` without `mem_ack`: `tgt` <= `redirect_pc`; go to DROP.
- DROP: `mem_req`=1, `mem_addr`=`pc` (the old address, held stable). A further `redirect` overwrites `tgt`, so the latest target wins. On `mem_ack`: drop the data, `pc` <= `tgt` (or `redirect_pc` if `redirect` is high in that same cycle); go to FETCH.
- FULL: `instr_valid`=1, `mem_req`=0.
  - `redirect`: drop the buffered instruction, `pc` <= `redirect_pc`, go to FETCH. A transfer is not counted even if `instr_ready` is high; the consumer must ignore it.
  - `instr_ready` without `redirect`: go to FETCH.
  - Neither: hold.

General rules:
- `redirect` has priority over every other event in every state.
- `instr` and `instr_pc` change only on a captured `mem_ack`. They hold their value in all other cycles, including after the instruction is accepted.
- One outstanding memory request at most. No prefetch and no bypass.

Reset:
- Asynchronous assertion forces IDLE immediately: `mem_req`=0, `instr_valid`=0, `pc`=RESET_PC, `tgt`=0, `instr`=0x00, `instr_pc`=0.
- An in-flight request is abandoned. The memory must tolerate `mem_req` dropping without an ack.

## Timing
- Reset release: first rising edge goes IDLE -> FETCH, so `mem_req`=1 with `mem_addr`=RESET_PC in the first cycle after release.
- Fetch latency: `instr_valid` rises in the cycle after the `mem_ack` cycle.
- Wait-state tolerance: any number of wait cycles; `mem_addr` is constant throughout.
- Throughput with zero-wait memory (ack in the same cycle as req) and `instr_ready`=1: one instruction every 2 cycles (FETCH, FULL).
- Redirect in IDLE, FULL, or an acked FETCH cycle: `mem_addr`=`redirect_pc` in the next cycle.
- Redirect during an unacked request: `mem_addr`=target in the cycle after the old request's ack.

## Test plan
1. Startup: RESET_PC=0, zero-wait memory holding 0x05, 0x41, 0x8A, 0xC4 at addresses 0-3, `instr_ready`=1 -> output pairs (0x05,0), (0x41,1), (0x8A,2), (0xC4,3), with `instr_valid` high on alternate cycles.
2. Wait states: ack withheld 3 cycles on address 0x10 -> `mem_req` stays 1 and `mem_addr`=0x10 for 4 cycles. Byte 0xA7 is captured, `instr_valid` rises 1 cycle after the ack, and `instr_pc`=0x10.
3. Backpressure: `instr_ready`=0 for 5 cycles in FULL -> `instr`, `instr_pc` and `instr_valid` held, `mem_req`=0. Raising `instr_ready` gives `mem_req`=1 at `pc`+1 on the next cycle.
4. Redirect in FULL, target 0x20, with `instr_ready`=1 -> next cycle `instr_valid`=0, `mem_addr`=0x20, and the old instruction is never re-presented.
5. Redirect in an unacked FETCH at 0x07, target 0x30, ack 2 cycles later -> `mem_addr` stays 0x07 until the ack, the returned data never appears on `instr`, then `mem_addr`=0x30. Repeat with a second redirect to 0x40 during DROP -> fetch resumes at 0x40.
6. Wrap and reset:
   - Instruction at `pc`=0xFF -> next `mem_addr`=0x00.
   - Assert `rst_n`=0 mid-FETCH -> `mem_req` and `instr_valid` drop without waiting for a clock edge, and fetch restarts at RESET_PC after release.
